reg_write_arbiter: RTL and testbench

//  Shares the register file's single write port among NUM_SRC writeback sources (ALU, load unit, mult/div).

---
 rtl/reg_write_arbiter_pkg.sv | 22 ++
 rtl/reg_write_arbiter_if.sv | 30 +++
 rtl/reg_write_arbiter_rr.sv | 57 +++++
 rtl/reg_write_arbiter.sv | 161 ++++++++++++++++
 tb/tb_reg_write_arbiter.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_write_arbiter_pkg.sv
// Shared constants, source indices and helpers for the register-file write-port arbiter.
package reg_write_arbiter_pkg;

  localparam int NUM_WB_SRC = 3;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 32;
  localparam int NUM_REGS   = 32;

  typedef enum logic [1:0] {
    WB_SRC_ALU  = 2'd0,
    WB_SRC_LOAD = 2'd1,
    WB_SRC_MDU  = 2'd2
  } wb_src_e;

  function automatic logic [NUM_REGS-1:0] reg_onehot(input logic [REG_ADDR_W-1:0] rd);
    logic [NUM_REGS-1:0] m;
    m     = {NUM_REGS{1'b0}};
    m[rd] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/reg_write_arbiter_if.sv
// Writeback request bundle and registered write-port/scoreboard outputs of the arbiter.
interface reg_write_arbiter_if
  import reg_write_arbiter_pkg::*;
#(
  parameter int NUM_SRC = NUM_WB_SRC,
  parameter int DATA_W  = REG_DATA_W,
  parameter int ADDR_W  = REG_ADDR_W
);

  logic [NUM_SRC-1:0]        req_valid_in;
  logic [NUM_SRC-1:0]        req_ready_out;
  logic [NUM_SRC*ADDR_W-1:0] req_rd_in;
  logic [NUM_SRC*DATA_W-1:0] req_data_in;
  logic                      we_out;
  logic [ADDR_W-1:0]         rd_out;
  logic [DATA_W-1:0]         write_data_out;
  logic [NUM_REGS-1:0]       pending_out;
  logic                      busy_out;

  modport master (
    output req_valid_in, req_rd_in, req_data_in,
    input  req_ready_out, we_out, rd_out, write_data_out, pending_out, busy_out
  );

  modport slave (
    input  req_valid_in, req_rd_in, req_data_in,
    output req_ready_out, we_out, rd_out, write_data_out, pending_out, busy_out
  );

endinterface

// File: rtl/reg_write_arbiter_rr.sv
// Round-robin one-hot arbiter; priority starts at the requester after the last one granted.
module rr_arbiter #(
  parameter int NUM_REQ = 3
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic               en_in,
  input  logic               update_in,
  input  logic [NUM_REQ-1:0] req_in,
  output logic [NUM_REQ-1:0] grant_out
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] last_q;
  logic [PTR_W-1:0] last_d;

  // Pick the first requester scanning forward from last_q + 1.
  always_comb begin
    logic found;
    int   idx;
    grant_out = {NUM_REQ{1'b0}};
    found     = 1'b0;
    idx       = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      idx = (int'(last_q) + off) % NUM_REQ;
      if (en_in && !found && req_in[idx]) begin
        grant_out[idx] = 1'b1;
        found          = 1'b1;
      end else begin
      end
    end
  end

  always_comb begin
    last_d = last_q;
    if (update_in) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant_out[i]) begin
          last_d = PTR_W'(i);
        end else begin
        end
      end
    end else begin
    end
  end

  // Reset to the last index so requester 0 wins first.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      last_q <= PTR_W'(NUM_REQ - 1);
    end else begin
      last_q <= last_d;
    end
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// Shares the register-file write port among writeback sources through one-entry buffers,
// a round-robin grant and a registered port, and exports a pending-destination scoreboard.
module reg_write_arbiter
  import reg_write_arbiter_pkg::*;
#(
  parameter int NUM_SRC = NUM_WB_SRC,
  parameter int DATA_W  = REG_DATA_W,
  parameter int ADDR_W  = REG_ADDR_W
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           stall_in,
  reg_write_arbiter_if.slave bus
);

  logic [NUM_SRC-1:0] full_q, full_d;
  logic [ADDR_W-1:0]  rd_q   [NUM_SRC];
  logic [ADDR_W-1:0]  rd_d   [NUM_SRC];
  logic [DATA_W-1:0]  data_q [NUM_SRC];
  logic [DATA_W-1:0]  data_d [NUM_SRC];

  logic               we_q, we_d;
  logic [ADDR_W-1:0]  rd_out_q, rd_out_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;

  logic [NUM_SRC-1:0] grant_s;
  logic [NUM_SRC-1:0] conflict_s;
  logic [NUM_SRC-1:0] ready_s;
  logic [NUM_SRC-1:0] accept_s;
  logic [ADDR_W-1:0]  req_rd_s   [NUM_SRC];
  logic [DATA_W-1:0]  req_data_s [NUM_SRC];
  logic [ADDR_W-1:0]  sel_rd_s;
  logic [DATA_W-1:0]  sel_data_s;
  logic [NUM_REGS-1:0] pending_s;
  logic               arb_en_s;

  assign arb_en_s = !rst_in && !stall_in;

  rr_arbiter #(.NUM_REQ(NUM_SRC)) u_rr_arbiter (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .en_in     (arb_en_s),
    .update_in (|grant_s),
    .req_in    (full_q),
    .grant_out (grant_s)
  );

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      req_rd_s[i]   = bus.req_rd_in[i*ADDR_W +: ADDR_W];
      req_data_s[i] = bus.req_data_in[i*DATA_W +: DATA_W];
    end
  end

  // A new offer must not overtake a same-rd entry that stays buffered this cycle.
  always_comb begin
    conflict_s = {NUM_SRC{1'b0}};
    ready_s    = {NUM_SRC{1'b0}};
    accept_s   = {NUM_SRC{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int j = 0; j < NUM_SRC; j++) begin
        if (j != i && full_q[j] && !grant_s[j] && rd_q[j] == req_rd_s[i] &&
            req_rd_s[i] != {ADDR_W{1'b0}}) begin
          conflict_s[i] = 1'b1;
        end else begin
        end
      end
      ready_s[i]  = !rst_in && (!full_q[i] || grant_s[i]) && !conflict_s[i];
      accept_s[i] = bus.req_valid_in[i] && ready_s[i];
    end
  end

  // Writes to r0 are acknowledged but dropped; a refill wins over the issue-clear.
  always_comb begin
    full_d = full_q;
    for (int i = 0; i < NUM_SRC; i++) begin
      rd_d[i]   = rd_q[i];
      data_d[i] = data_q[i];
      if (accept_s[i] && req_rd_s[i] != {ADDR_W{1'b0}}) begin
        full_d[i] = 1'b1;
        rd_d[i]   = req_rd_s[i];
        data_d[i] = req_data_s[i];
      end else if (grant_s[i]) begin
        full_d[i] = 1'b0;
      end else begin
      end
    end
  end

  always_comb begin
    sel_rd_s   = {ADDR_W{1'b0}};
    sel_data_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_s[i]) begin
        sel_rd_s   = rd_q[i];
        sel_data_s = data_q[i];
      end else begin
      end
    end
  end

  always_comb begin
    we_d     = we_q;
    rd_out_d = rd_out_q;
    wdata_d  = wdata_q;
    if (stall_in) begin
      we_d = we_q;
    end else if (|grant_s) begin
      we_d     = 1'b1;
      rd_out_d = sel_rd_s;
      wdata_d  = sel_data_s;
    end else begin
      we_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      full_q   <= {NUM_SRC{1'b0}};
      we_q     <= 1'b0;
      rd_out_q <= {ADDR_W{1'b0}};
      wdata_q  <= {DATA_W{1'b0}};
      for (int i = 0; i < NUM_SRC; i++) begin
        rd_q[i]   <= {ADDR_W{1'b0}};
        data_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      full_q   <= full_d;
      we_q     <= we_d;
      rd_out_q <= rd_out_d;
      wdata_q  <= wdata_d;
      for (int i = 0; i < NUM_SRC; i++) begin
        rd_q[i]   <= rd_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  always_comb begin
    pending_s = {NUM_REGS{1'b0}};
    for (int i = 0; i < NUM_SRC; i++) begin
      if (full_q[i]) begin
        pending_s = pending_s | reg_onehot(rd_q[i]);
      end else begin
      end
    end
    if (we_q) begin
      pending_s = pending_s | reg_onehot(rd_out_q);
    end else begin
    end
    pending_s[0] = 1'b0;
  end

  assign bus.req_ready_out  = ready_s;
  assign bus.we_out         = we_q;
  assign bus.rd_out         = rd_out_q;
  assign bus.write_data_out = wdata_q;
  assign bus.pending_out    = pending_s;
  assign bus.busy_out       = (|full_q) || we_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: per-cycle comparison against a transaction-level model
// plus hand-computed checkpoints for each scenario.
module tb_reg_write_arbiter;
  import reg_write_arbiter_pkg::*;

  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst;
  logic stall;

  reg_write_arbiter_if #(.NUM_SRC(N), .DATA_W(DW), .ADDR_W(AW)) bus ();

  reg_write_arbiter #(.NUM_SRC(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk_in   (clk),
    .rst_in   (rst),
    .stall_in (stall),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one slot per source, the port, the last winner, and a register file fed by the DUT port.
  bit          m_init = 1'b0;
  bit          m_full [N];
  logic [4:0]  m_rd   [N];
  logic [31:0] m_data [N];
  int          m_last;
  logic        m_we;
  logic [4:0]  m_rdo;
  logic [31:0] m_wd;
  logic [31:0] tb_rf [32];

  function automatic logic [4:0] in_rd(int s);
    return bus.req_rd_in[s*AW +: AW];
  endfunction

  function automatic int m_grant();
    if (rst || stall) return -1;
    for (int off = 1; off <= N; off++) begin
      if (m_full[(m_last + off) % N]) return (m_last + off) % N;
    end
    return -1;
  endfunction

  function automatic bit m_ready(int i);
    int g;
    g = m_grant();
    if (rst) return 1'b0;
    if (m_full[i] && g != i) return 1'b0;
    for (int j = 0; j < N; j++) begin
      if (j != i && m_full[j] && g != j && m_rd[j] == in_rd(i) && in_rd(i) != 5'd0) return 1'b0;
    end
    return 1'b1;
  endfunction

  function automatic logic [31:0] m_pending();
    logic [31:0] p;
    p = 32'd0;
    for (int i = 0; i < N; i++) if (m_full[i]) p[m_rd[i]] = 1'b1;
    if (m_we) p[m_rdo] = 1'b1;
    p[0] = 1'b0;
    return p;
  endfunction

  always @(posedge clk) begin
    bit [N-1:0] acc;
    int g;
    if (rst) begin
      for (int i = 0; i < N; i++) m_full[i] = 1'b0;
      m_last = N - 1;
      m_we = 1'b0; m_rdo = 5'd0; m_wd = 32'd0;
      m_init = 1'b1;
    end else begin
      g = m_grant();
      for (int i = 0; i < N; i++) acc[i] = bus.req_valid_in[i] && m_ready(i);
      if (!stall) begin
        if (g >= 0) begin
          m_we = 1'b1; m_rdo = m_rd[g]; m_wd = m_data[g];
          m_full[g] = 1'b0; m_last = g;
        end else begin
          m_we = 1'b0;
        end
      end
      for (int i = 0; i < N; i++) begin
        if (acc[i] && in_rd(i) != 5'd0) begin
          m_full[i] = 1'b1; m_rd[i] = in_rd(i); m_data[i] = bus.req_data_in[i*DW +: DW];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      logic [N-1:0] er;
      bit busy;
      for (int i = 0; i < N; i++) er[i] = m_ready(i);
      busy = m_we;
      for (int i = 0; i < N; i++) busy = busy | m_full[i];
      check("ready", bus.req_ready_out, er);
      check("we", bus.we_out, m_we);
      check("rd_out", bus.rd_out, m_rdo);
      check("wdata", bus.write_data_out, m_wd);
      check("pending", bus.pending_out, m_pending());
      check("busy", bus.busy_out, busy);
      if (bus.we_out === 1'b1 && bus.rd_out != 5'd0) tb_rf[bus.rd_out] = bus.write_data_out;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(int s, logic [4:0] r, logic [31:0] d);
    bus.req_valid_in[s] = 1'b1;
    bus.req_rd_in[s*AW +: AW] = r;
    bus.req_data_in[s*DW +: DW] = d;
  endtask

  task automatic drop(int s);
    bus.req_valid_in[s] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int r = 0; r < 32; r++) tb_rf[r] = 32'd0;
    rst = 1'b1; stall = 1'b0;
    bus.req_valid_in = '0; bus.req_rd_in = '0; bus.req_data_in = '0;
    tick(); tick();
    @(negedge clk);
    check("rst_we", bus.we_out, 1'b0);
    check("rst_pending", bus.pending_out, 32'd0);

    // 1: single write from the ALU
    tick(); rst = 1'b0; offer(WB_SRC_ALU, 5'd5, 32'h1234);
    @(negedge clk); check("t1_ready", bus.req_ready_out[0], 1'b1);
    tick(); drop(0);
    @(negedge clk); check("t1_pend_buf", bus.pending_out, 32'h0000_0020);
    check("t1_we_lat", bus.we_out, 1'b0);
    tick();
    @(negedge clk); check("t1_we", bus.we_out, 1'b1); check("t1_rd", bus.rd_out, 5'd5);
    check("t1_pend_port", bus.pending_out, 32'h0000_0020);
    tick();
    @(negedge clk); check("t1_pend_clr", bus.pending_out, 32'd0);
    check("t1_rf5", tb_rf[5], 32'h1234);

    // 2: three-way burst from reset priority, then next round starts at source 0
    tick(); rst = 1'b1;
    tick(); rst = 1'b0;
    offer(0, 5'd1, 32'h101); offer(1, 5'd2, 32'h202); offer(2, 5'd3, 32'h303);
    @(negedge clk); check("t2_ready_all", bus.req_ready_out, 3'b111);
    tick(); drop(0); drop(1); drop(2);
    tick(); @(negedge clk); check("t2_rd_a", bus.rd_out, 5'd1); check("t2_we_a", bus.we_out, 1'b1);
    tick(); @(negedge clk); check("t2_rd_b", bus.rd_out, 5'd2);
    tick(); @(negedge clk); check("t2_rd_c", bus.rd_out, 5'd3);
    offer(0, 5'd4, 32'h404); offer(2, 5'd6, 32'h606);
    tick(); drop(0); drop(2);
    tick(); @(negedge clk); check("t2_rd_d", bus.rd_out, 5'd4);
    tick(); @(negedge clk); check("t2_rd_e", bus.rd_out, 5'd6);

    // 2b: back-to-back offers from one source (issue and refill at one edge)
    tick(); offer(0, 5'd10, 32'hA0A);
    tick(); offer(0, 5'd11, 32'hB0B);
    @(negedge clk); check("t2b_ready_refill", bus.req_ready_out[0], 1'b1);
    tick(); drop(0);
    @(negedge clk); check("t2b_rd_a", bus.rd_out, 5'd10);
    tick(); @(negedge clk); check("t2b_rd_b", bus.rd_out, 5'd11);
    check("t2b_data_b", bus.write_data_out, 32'hB0B);
    tick(); @(negedge clk); check("t2b_idle", bus.we_out, 1'b0);

    // 3: same-rd offer blocked while the older entry is held by a stall
    tick(); stall = 1'b1; offer(1, 5'd7, 32'h7777_0001);
    tick(); drop(1); offer(2, 5'd7, 32'h7777_0002);
    @(negedge clk); check("t3_block_a", bus.req_ready_out[2], 1'b0);
    tick(); @(negedge clk); check("t3_block_b", bus.req_ready_out[2], 1'b0);
    tick(); stall = 1'b0;
    @(negedge clk); check("t3_ready_on_issue", bus.req_ready_out[2], 1'b1);
    tick(); drop(2);
    @(negedge clk); check("t3_rd_old", bus.rd_out, 5'd7); check("t3_data_old", bus.write_data_out, 32'h7777_0001);
    tick(); @(negedge clk); check("t3_data_new", bus.write_data_out, 32'h7777_0002);
    tick(); @(negedge clk); check("t3_rf7", tb_rf[7], 32'h7777_0002);

    // 4: stall freezes an issued write for four cycles
    tick(); offer(0, 5'd9, 32'h9999);
    tick(); drop(0);
    tick(); stall = 1'b1; offer(1, 5'd12, 32'hC0C);
    @(negedge clk); check("t4_we_hold0", bus.we_out, 1'b1); check("t4_rd_hold0", bus.rd_out, 5'd9);
    tick(); drop(1);
    @(negedge clk); check("t4_pend", bus.pending_out, 32'h0000_1200);
    for (int k = 0; k < 3; k++) begin
      tick();
      @(negedge clk); check("t4_rd_hold", bus.rd_out, 5'd9); check("t4_data_hold", bus.write_data_out, 32'h9999);
    end
    stall = 1'b0;
    tick(); @(negedge clk); check("t4_resume_rd", bus.rd_out, 5'd12); check("t4_resume_we", bus.we_out, 1'b1);

    // 5: r0 writes are acknowledged and dropped
    tick(); offer(0, 5'd0, 32'hFFFF);
    @(negedge clk); check("t5_ready", bus.req_ready_out[0], 1'b1);
    tick(); drop(0);
    @(negedge clk); check("t5_we", bus.we_out, 1'b0); check("t5_pend", bus.pending_out, 32'd0);
    check("t5_busy", bus.busy_out, 1'b0);
    tick(); @(negedge clk); check("t5_we_later", bus.we_out, 1'b0);

    // 6: reset discards buffered and on-port writes
    tick(); offer(0, 5'd20, 32'h2020);
    tick(); drop(0);
    tick(); stall = 1'b1; offer(1, 5'd21, 32'h2121); offer(2, 5'd22, 32'h2222);
    tick(); drop(1); drop(2);
    @(negedge clk); check("t6_pend_full", bus.pending_out, 32'h0070_0000); check("t6_busy", bus.busy_out, 1'b1);
    rst = 1'b1; offer(0, 5'd23, 32'h2323);
    @(posedge clk); #1;
    @(negedge clk); check("t6_we_rst", bus.we_out, 1'b0); check("t6_pend_rst", bus.pending_out, 32'd0);
    check("t6_busy_rst", bus.busy_out, 1'b0); check("t6_ready_rst", bus.req_ready_out, 3'b000);
    tick(); @(negedge clk); check("t6_ready_held", bus.req_ready_out, 3'b000);
    rst = 1'b0; stall = 1'b0; drop(0);
    tick(); tick();
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
